// File: rtl/v_mem_seq_pkg.sv
// Shared vector memory definitions: element geometry, width codes,
// sequencer states and the captured request bundle.
package v_mem_seq_pkg;

  localparam int VLEN   = 512;
  localparam int ELEN   = 64;
  localparam int ADDR_W = 64;
  localparam int NELEM  = VLEN / ELEN;

  typedef enum logic [1:0] {
    W8,
    W16,
    W32,
    W64
  } width_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  typedef struct packed {
    logic              we;
    logic              sign;
    width_e            width;
    logic [2:0]        last;
    logic [ADDR_W-1:0] addr;
    logic [VLEN-1:0]   wdata;
  } mreq_t;

  // Unit-stride ops and oversized codes both move full 64-bit elements.
  function automatic width_e clamp_width(
    input logic       ext,
    input logic [2:0] w
  );
    if (!ext || w > 3'd3) return W64;
    return width_e'(w[1:0]);
  endfunction

endpackage

// File: rtl/v_mem_lane.sv
// Byte-lane steering for one element: load extract/extend and
// store data/strobe positioning within a 64-bit memory word.
module v_mem_lane
  import v_mem_seq_pkg::*;
(
  input  logic [2:0]  lane,
  input  width_e      width,
  input  logic        sign,
  input  logic [63:0] rdata,
  input  logic [63:0] wsrc,
  output logic [63:0] ldata,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb
);

  logic [5:0]  sh;
  logic [63:0] shifted;
  logic [63:0] wtrunc;
  logic [7:0]  smask;

  assign sh      = {lane, 3'b000};
  assign shifted = rdata >> sh;

  always_comb begin
    ldata  = shifted;
    wtrunc = wsrc;
    smask  = 8'hff;
    unique case (width)
      W8: begin
        ldata  = {{56{sign & shifted[7]}}, shifted[7:0]};
        wtrunc = {56'd0, wsrc[7:0]};
        smask  = 8'h01;
      end
      W16: begin
        ldata  = {{48{sign & shifted[15]}}, shifted[15:0]};
        wtrunc = {48'd0, wsrc[15:0]};
        smask  = 8'h03;
      end
      W32: begin
        ldata  = {{32{sign & shifted[31]}}, shifted[31:0]};
        wtrunc = {32'd0, wsrc[31:0]};
        smask  = 8'h0f;
      end
      W64: begin
        ldata  = shifted;
        wtrunc = wsrc;
        smask  = 8'hff;
      end
    endcase
  end

  assign wdata = wtrunc << sh;
  assign wstrb = smask << lane;

endmodule

// File: rtl/v_mem_seq.sv
// Vector load/store sequencer: one memory access per element,
// stalls decode via busy_o until the response pulse.
module v_mem_seq
  import v_mem_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic              req_ext_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [2:0]        req_width_i,
  input  logic [2:0]        req_len_i,
  input  logic              req_sign_i,
  input  logic [VLEN-1:0]   req_wdata_i,
  output logic              mem_en_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wstrb_o,
  output logic [63:0]       mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [63:0]       mem_rdata_i,
  output logic              resp_valid_o,
  output logic              resp_err_o,
  output logic [VLEN-1:0]   resp_data_o,
  output logic              busy_o
);

  state_e          state_q;
  state_e          state_d;
  mreq_t           req_q;
  logic [2:0]      k_q;
  logic [VLEN-1:0] res_q;
  logic            err_q;

  logic              hs;
  logic              last;
  logic              misalign;
  logic [2:0]        amask;
  logic [ADDR_W-1:0] ea;
  logic [63:0]       ldata;
  logic [63:0]       lwdata;
  logic [7:0]        lwstrb;

  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign resp_err_o   = err_q;
  assign resp_data_o  = res_q;

  assign hs   = req_valid_i && req_ready_o;
  assign last = (k_q == req_q.last);

  // Element stride is a power of two, so k*B is a shift.
  assign ea       = req_q.addr + (ADDR_W'(k_q) << req_q.width);
  assign amask    = 3'((4'd1 << req_q.width) - 4'd1);
  assign misalign = (ea[2:0] & amask) != 3'd0;

  v_mem_lane u_lane (
    .lane  (ea[2:0]),
    .width (req_q.width),
    .sign  (req_q.sign),
    .rdata (mem_rdata_i),
    .wsrc  (req_q.wdata[{k_q, 6'd0} +: ELEN]),
    .ldata (ldata),
    .wdata (lwdata),
    .wstrb (lwstrb)
  );

  always_comb begin
    state_d     = state_q;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wstrb_o = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      IDLE: if (hs) state_d = REQ;
      REQ: begin
        if (misalign) begin
          state_d = DONE;
        end else begin
          mem_en_o   = 1'b1;
          mem_we_o   = req_q.we;
          mem_addr_o = {ea[ADDR_W-1:3], 3'b000};
          if (req_q.we) begin
            mem_wstrb_o = lwstrb;
            mem_wdata_o = lwdata;
          end
          if (mem_ready_i) begin
            if (!req_q.we) state_d = WAIT;
            else if (last) state_d = DONE;
          end
        end
      end
      WAIT: if (mem_rvalid_i) state_d = last ? DONE : REQ;
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      k_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        req_q.we    <= req_we_i;
        req_q.sign  <= req_sign_i;
        req_q.width <= clamp_width(req_ext_i, req_width_i);
        req_q.last  <= req_ext_i ? req_len_i : 3'(NELEM - 1);
        req_q.addr  <= req_addr_i;
        req_q.wdata <= req_wdata_i;
        k_q         <= '0;
        res_q       <= '0;
        err_q       <= 1'b0;
      end
      if (state_q == REQ && misalign) err_q <= 1'b1;
      if (state_q == REQ && !misalign && mem_ready_i &&
          req_q.we && !last)
        k_q <= k_q + 3'd1;
      if (state_q == WAIT && mem_rvalid_i) begin
        res_q[{k_q, 6'd0} +: ELEN] <= ldata;
        if (!last) k_q <= k_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_v_mem_seq.sv
// Randomized bench for v_mem_seq: byte-level memory model, directed
// corner cases and an element-by-element reference of each operation.
module tb_v_mem_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic         req_we_i = 1'b0;
  logic         req_ext_i = 1'b0;
  logic [63:0]  req_addr_i = '0;
  logic [2:0]   req_width_i = '0;
  logic [2:0]   req_len_i = '0;
  logic         req_sign_i = 1'b0;
  logic [511:0] req_wdata_i = '0;
  logic         mem_en_o;
  logic         mem_ready_i = 1'b0;
  logic         mem_we_o;
  logic [63:0]  mem_addr_o;
  logic [7:0]   mem_wstrb_o;
  logic [63:0]  mem_wdata_o;
  logic         mem_rvalid_i = 1'b0;
  logic [63:0]  mem_rdata_i = '0;
  logic         resp_valid_o;
  logic         resp_err_o;
  logic [511:0] resp_data_o;
  logic         busy_o;

  v_mem_seq dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_ext_i    (req_ext_i),
    .req_addr_i   (req_addr_i),
    .req_width_i  (req_width_i),
    .req_len_i    (req_len_i),
    .req_sign_i   (req_sign_i),
    .req_wdata_i  (req_wdata_i),
    .mem_en_o     (mem_en_o),
    .mem_ready_i  (mem_ready_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_err_o   (resp_err_o),
    .resp_data_o  (resp_data_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } acc_t;

  int n_cmp = 0;
  int n_bad = 0;

  bit [7:0] bmem [bit [63:0]];
  acc_t     exp_q[$];
  acc_t     got_q[$];

  bit          zw = 1'b1;
  bit          inj_rv = 1'b0;
  int          stall_left = 0;
  logic [63:0] stall_addr = '0;
  bit          rd_pend = 1'b0;
  int          rd_lat = 0;
  logic [63:0] rd_addr = '0;
  bit          was_stall = 1'b0;
  acc_t        prev;

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic bit [7:0] rd_byte(input logic [63:0] a);
    if (!bmem.exists(a)) bmem[a] = 8'($urandom);
    return bmem[a];
  endfunction

  function automatic logic [63:0] rd_word(input logic [63:0] a);
    logic [63:0] v;
    for (int j = 0; j < 8; j++) v[8*j +: 8] = rd_byte(a + 64'(j));
    return v;
  endfunction

  task automatic wr_word(input logic [63:0] a, input logic [63:0] v);
    for (int j = 0; j < 8; j++) bmem[a + 64'(j)] = v[8*j +: 8];
  endtask

  // Memory: accepts on en&&ready, returns read data after a latency,
  // and throws stray rvalid pulses while the sequencer is issuing.
  always @(negedge clk) begin
    acc_t cur;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = {32'($urandom), 32'($urandom)};
    if (inj_rv) begin
      mem_rvalid_i = 1'b1;
      inj_rv = 1'b0;
    end else if (rd_pend) begin
      if (rd_lat == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rd_word(rd_addr);
        rd_pend      = 1'b0;
      end else begin
        rd_lat--;
      end
    end else if (!zw && mem_en_o && $urandom_range(0, 3) == 0) begin
      mem_rvalid_i = 1'b1;
    end
    mem_ready_i = zw ? 1'b1 : ($urandom_range(0, 2) != 0);
    if (stall_left > 0 && mem_en_o && mem_addr_o == stall_addr) begin
      mem_ready_i = 1'b0;
      stall_left--;
    end
    cur = '{we: mem_we_o, addr: mem_addr_o,
            strb: mem_wstrb_o, wdata: mem_wdata_o};
    if (was_stall) begin
      check("hold_en", mem_en_o, 1'b1);
      check("hold_fields", cur, prev);
    end
    was_stall = mem_en_o && !mem_ready_i;
    prev = cur;
    if (mem_en_o && mem_ready_i) begin
      got_q.push_back(cur);
      if (mem_we_o) begin
        for (int j = 0; j < 8; j++)
          if (mem_wstrb_o[j]) bmem[mem_addr_o + 64'(j)] = mem_wdata_o[8*j +: 8];
      end else begin
        rd_pend = 1'b1;
        rd_addr = mem_addr_o;
        rd_lat  = zw ? 0 : $urandom_range(0, 2);
      end
    end
  end

  // Reference: walk elements, byte by byte, against current memory.
  task automatic model(
    input  logic         we,
    input  logic         ext,
    input  logic [63:0]  addr,
    input  logic [2:0]   width,
    input  logic [2:0]   len,
    input  logic         sign,
    input  logic [511:0] wd,
    output logic [511:0] edata,
    output logic         eerr
  );
    int          n;
    int          b;
    int          ln;
    logic [63:0] ea;
    logic [63:0] val;
    acc_t        a;
    exp_q.delete();
    edata = '0;
    eerr  = 1'b0;
    n = ext ? int'(len) + 1 : 8;
    b = (!ext || width >= 3'd3) ? 8 : (1 << width);
    for (int k = 0; k < n; k++) begin
      ea = addr + 64'(k * b);
      if ((ea & 64'(b - 1)) != 64'd0) begin
        eerr = 1'b1;
        break;
      end
      ln = int'(ea[2:0]);
      a  = '{we: we, addr: ea & ~64'h7, strb: 8'h0, wdata: 64'h0};
      if (we) begin
        for (int j = 0; j < b; j++) begin
          a.strb[ln + j] = 1'b1;
          a.wdata[8*(ln + j) +: 8] = wd[64*k + 8*j +: 8];
        end
      end else begin
        val = '0;
        for (int j = 0; j < b; j++)
          val[8*j +: 8] = rd_byte(ea + 64'(j));
        if (sign && b < 8 && val[8*b - 1])
          val = val | ~((64'd1 << (8 * b)) - 64'd1);
        edata[64*k +: 64] = val;
      end
      exp_q.push_back(a);
    end
  endtask

  task automatic issue(
    input logic         we,
    input logic         ext,
    input logic [63:0]  addr,
    input logic [2:0]   width,
    input logic [2:0]   len,
    input logic         sign,
    input logic [511:0] wd
  );
    check("ready_idle", req_ready_o, 1'b1);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_ext_i   = ext;
    req_addr_i  = addr;
    req_width_i = width;
    req_len_i   = len;
    req_sign_i  = sign;
    req_wdata_i = wd;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_we_i    = 1'($urandom);
    req_ext_i   = 1'($urandom);
    req_addr_i  = {32'($urandom), 32'($urandom)};
    req_width_i = 3'($urandom);
    req_len_i   = 3'($urandom);
    req_sign_i  = 1'($urandom);
    for (int j = 0; j < 16; j++) req_wdata_i[32*j +: 32] = $urandom;
  endtask

  task automatic run_op(
    input logic         we,
    input logic         ext,
    input logic [63:0]  addr,
    input logic [2:0]   width,
    input logic [2:0]   len,
    input logic         sign,
    input logic [511:0] wd,
    input int           exp_cyc
  );
    logic [511:0] edata;
    logic         eerr;
    int           cyc;
    model(we, ext, addr, width, len, sign, wd, edata, eerr);
    got_q.delete();
    issue(we, ext, addr, width, len, sign, wd);
    cyc = 1;
    while (resp_valid_o !== 1'b1 && cyc < 400) begin
      check("busy", busy_o, 1'b1);
      check("ready_busy", req_ready_o, 1'b0);
      @(posedge clk);
      #1;
      cyc++;
    end
    check("resp_valid", resp_valid_o, 1'b1);
    check("resp_err", resp_err_o, eerr);
    check("resp_data", resp_data_o, edata);
    if (exp_cyc > 0) check("latency", cyc, exp_cyc);
    check("n_acc", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("acc%0d", i), got_q[i], exp_q[i]);
    @(posedge clk);
    #1;
    check("pulse", resp_valid_o, 1'b0);
    check("hold_data", resp_data_o, edata);
    check("hold_err", resp_err_o, eerr);
    check("ready_after", req_ready_o, 1'b1);
  endtask

  initial begin
    logic [511:0] wd;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_en", mem_en_o, 1'b0);
    check("rst_valid", resp_valid_o, 1'b0);
    check("rst_err", resp_err_o, 1'b0);
    check("rst_data", resp_data_o, 512'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Unit-stride load, zero-wait memory.
    for (int k = 0; k < 8; k++)
      wr_word(64'h1000 + 64'(8 * k), 64'h1111_1111_1111_1111 * 64'(k + 1));
    run_op(1'b0, 1'b0, 64'h1000, 3'd0, 3'd0, 1'b0, '0, 17);
    check("vle_slot0", resp_data_o[63:0], 64'h1111_1111_1111_1111);
    check("vle_slot7", resp_data_o[511:448], 64'h8888_8888_8888_8888);
    check("vle_addr0", got_q[0].addr, 64'h1000);
    check("vle_addr7", got_q[7].addr, 64'h1038);

    // Byte loads with sign and zero extension.
    bmem[64'h2005] = 8'h80;
    bmem[64'h2006] = 8'h7f;
    bmem[64'h2007] = 8'hff;
    bmem[64'h2008] = 8'h01;
    run_op(1'b0, 1'b1, 64'h2005, 3'd0, 3'd3, 1'b1, '0, 9);
    check("vlx_s0", resp_data_o[63:0], 64'hffff_ffff_ffff_ff80);
    check("vlx_s2", resp_data_o[191:128], 64'hffff_ffff_ffff_ffff);
    check("vlx_hi", resp_data_o[511:256], 256'd0);
    run_op(1'b0, 1'b1, 64'h2005, 3'd0, 3'd3, 1'b0, '0, 9);
    check("vlx_z0", resp_data_o[63:0], 64'h80);

    // Halfword store straddling a word boundary.
    wd = '0;
    wd[63:0]   = 64'haaaa_bbbb_cccc_1234;
    wd[127:64] = 64'h5678;
    run_op(1'b1, 1'b1, 64'h3006, 3'd1, 3'd1, 1'b0, wd, 3);
    check("vsx_a0", got_q[0].addr, 64'h3000);
    check("vsx_s0", got_q[0].strb, 8'hc0);
    check("vsx_d0", got_q[0].wdata[63:48], 16'h1234);
    check("vsx_a1", got_q[1].addr, 64'h3008);
    check("vsx_s1", got_q[1].strb, 8'h03);
    check("vsx_d1", got_q[1].wdata[15:0], 16'h5678);

    // Back-pressure on element 2.
    stall_addr = 64'h1010;
    stall_left = 3;
    run_op(1'b0, 1'b0, 64'h1000, 3'd0, 3'd0, 1'b0, '0, 20);
    check("stall_used", stall_left, 0);

    // Misaligned word access aborts before issuing.
    run_op(1'b0, 1'b1, 64'h4002, 3'd2, 3'd3, 1'b0, '0, 2);

    // Reset in the WAIT of element 3, then a stray rvalid.
    got_q.delete();
    issue(1'b0, 1'b0, 64'h1000, 3'd0, 3'd0, 1'b0, '0);
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_wait", mem_en_o, 1'b0);
    check("pre_rst_acc", got_q.size(), 4);
    rst = 1'b0;
    #1;
    check("arst_busy", busy_o, 1'b0);
    check("arst_ready", req_ready_o, 1'b1);
    check("arst_data", resp_data_o, 512'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    inj_rv = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("post_rst_valid", resp_valid_o, 1'b0);
      check("post_rst_busy", busy_o, 1'b0);
      check("post_rst_data", resp_data_o, 512'd0);
    end
    run_op(1'b0, 1'b0, 64'h1000, 3'd0, 3'd0, 1'b0, '0, 17);

    // Random operations against a randomly stalling memory.
    zw = 1'b0;
    for (int i = 0; i < 60; i++) begin
      logic        we;
      logic        ext;
      logic        sg;
      logic [2:0]  w;
      logic [2:0]  l;
      logic [63:0] a;
      int          b;
      we  = 1'($urandom);
      ext = ($urandom_range(0, 3) != 0);
      sg  = 1'($urandom);
      w   = 3'($urandom);
      l   = 3'($urandom);
      for (int j = 0; j < 16; j++) wd[32*j +: 32] = $urandom;
      b = (!ext || w >= 3'd3) ? 8 : (1 << w);
      a = 64'h9000 + 64'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0)
        a = 64'hffff_ffff_ffff_ffe0 + 64'($urandom_range(0, 31));
      if ($urandom_range(0, 4) != 0) a = a & ~64'(b - 1);
      run_op(we, ext, a, w, l, sg, wd, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/v_mem_seq.md
Name: v_mem_seq

Overview:
- Multi-cycle sequencer between the vector decode stage and a 64-bit byte-addressed data memory port.
- Executes VLE64/VSE64 (8 x 64-bit elements) and VLX/VSX (len+1 elements of 8/16/32/64 bits). Issues one memory access per element.
- Assembles load results into a 512-bit vector with zero/sign extension; truncates store elements.
- Holds `busy_o` high so the pipeline stalls until the operation completes.

Parameters:
- VLEN, 512, vector register width in bits
- ELEN, 64, element slot width; element i occupies bits [64i+63:64i]
- ADDR_W, 64, memory address width
- NELEM, 8, VLEN/ELEN, maximum element count

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  operation request from decode
- req_ready_o  out  1  sequencer can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_ext_i  in  1  1 = VLX/VSX (use width/len), 0 = VLE64/VSE64
- req_addr_i  in  ADDR_W  base byte address (offset already added)
- req_width_i  in  3  element width code: 0 = 8b, 1 = 16b, 2 = 32b, 3 = 64b
- req_len_i  in  3  element count minus 1
- req_sign_i  in  1  load extension: 1 = sign, 0 = zero
- req_wdata_i  in  VLEN  store source vector
- mem_en_o  out  1  memory access valid
- mem_ready_i  in  1  memory accepts the access this cycle
- mem_we_o  out  1  write enable
- mem_addr_o  out  ADDR_W  8-byte-aligned word address
- mem_wstrb_o  out  8  byte write strobes
- mem_wdata_o  out  64  write data, lane-positioned
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  64  read data word
- resp_valid_o  out  1  one-cycle completion pulse
- resp_err_o  out  1  qualifies resp_valid_o: misaligned element, operation aborted
- resp_data_o  out  VLEN  assembled load vector; 0 for stores
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, element counter 0, result register 0. All outputs 0 except req_ready_o = 1.
- Asynchronous reset mid-operation:
  - Immediate return to IDLE.
  - No response is produced; pending mem_rvalid_i is ignored.
  - Memory writes already accepted are not undone.
- Request capture: a handshake occurs when req_valid_i && req_ready_o. req_ready_o = (state == IDLE).
  - All req_* fields are registered on the handshake.
  - Element count N = 8 if !req_ext_i, else req_len_i + 1.
  - Element bytes B = 8 if !req_ext_i, else 1 << min(req_width_i, 3). Width codes 4–7 are treated as 64-bit.
  - The result register clears on the handshake.
- Element address: EA(k) = addr + k*B (ADDR_W-bit wrap-around allowed).
  - mem_addr_o = EA & ~7.
  - lane = EA[2:0].
- Alignment: each element must be naturally aligned (EA mod B == 0).
  - The check runs in REQ before issuing.
  - On misalignment: no access, go to DONE with resp_err_o = 1. resp_data_o holds the elements completed so far.
- FSM:
  - IDLE: go to REQ on handshake.
  - REQ: mem_en_o = 1 with the fields of element k. Hold all mem_* outputs stable until mem_ready_i. On acceptance:
    - load → WAIT;
    - store → k++, then REQ if k < N-1 else DONE.
  - WAIT: mem_en_o = 0. On mem_rvalid_i:
    - extract B bytes from mem_rdata_i at lane;
    - extend to 64 bits (sign if req_sign, else zero);
    - write result slot k;
    - then k++ → REQ, or → DONE after the last element.
  - DONE: resp_valid_o = 1 for exactly one cycle, then IDLE.
- Store data: source = req_wdata[64k +: B*8] (truncation).
  - mem_wdata_o = source << (8*lane).
  - mem_wstrb_o = ((1<<B)-1) << lane.
- Loads: mem_we_o = 0, mem_wstrb_o = 0. Slots ≥ N read as 0.
- resp_data_o and resp_err_o hold their values until the next handshake.
- Timing with zero-wait memory (mem_ready_i = 1, rvalid one cycle after acceptance), handshake at cycle 0:
  - load: resp_valid at cycle 2N+1;
  - store: resp_valid at cycle N+1.
- mem_rvalid_i outside WAIT is ignored.
- mem_ready_i outside REQ is ignored.

Decomposition:
- Shared package/defines (same file as existing vector defines):
  - width codes W8/W16/W32/W64;
  - FSM state encodings IDLE/REQ/WAIT/DONE;
  - NELEM and ELEN constants.
- One natural sub-module, v_mem_lane: purely combinational.
  - Load path: lane extraction plus sign/zero extension.
  - Store path: wdata shift and wstrb generation.
  - Reused for both directions.

Test Plan:
- VLE64, addr 0x1000, memory word k = 0x1111_1111_1111_1111*(k+1), zero-wait memory
  -> 8 reads at 0x1000..0x1038; resp_valid at cycle 17; slot k = word k.
- VLX, width 0, len 3, sign 1, addr 0x2005, bytes 0x80,0x7F,0xFF,0x01
  -> slots 0..3 = 0xFFFF_FFFF_FFFF_FF80, 0x7F, 0xFFFF_FFFF_FFFF_FFFF, 0x01; slots 4..7 = 0.
  Same with sign 0 -> slot 0 = 0x80.
- VSX, width 1, len 1, addr 0x3006, req_wdata slot0 = 0xAAAA_BBBB_CCCC_1234, slot1 = 0x5678
  -> access 1: addr 0x3000, wstrb 0xC0, wdata[63:48] = 0x1234;
     access 2: addr 0x3008, wstrb 0x03, wdata[15:0] = 0x5678;
     resp_valid at cycle 3, resp_err = 0.
- Back-pressure: VLE64 with mem_ready_i low for 3 cycles on element 2
  -> mem_addr_o = base+0x10 and mem_en_o held stable throughout; final data correct; req_ready_o = 0 until IDLE.
- Misaligned VLX, width 2, addr 0x4002
  -> no mem_en_o; resp_valid and resp_err = 1 at cycle 2; resp_data = 0.
- Reset asserted during WAIT of element 3
  -> outputs zero asynchronously; later mem_rvalid_i is ignored; no resp_valid; next request after rst deassertion completes normally.
